instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have the following ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- load_en, input, 1: write one byte into instruction memory.
- load_addr, input, 8: byte address for the load.
- load_data, input, 8: byte value for the load.
- start, input, 1: begin fetching at byte address 0.
- redirect_valid, input, 1: branch or jump redirect request.
- redirect_pc, input, 8: redirect target byte address.
- ready, input, 1: the downstream core accepts the presented instruction.
- instr, output, 32: fetched instruction word.
- pc_out, output, 8: byte address of instr.
- instr_valid, output, 1: instr and pc_out are valid.
- halted, output, 1: the fetch unit is in HALT.

Function
REQ-002 The block SHALL contain 256 x 8-bit byte-addressed instruction memory.
REQ-003 The word at address A SHALL be {mem[A+3], mem[A+2], mem[A+1], mem[A]}, with address addition taken mod 256.
REQ-004 The FSM SHALL have three states: IDLE, RUN and HALT.
REQ-005 In IDLE or HALT, load_en=1 SHALL write load_data to mem[load_addr] on the clock edge.
REQ-006 load_en SHALL be ignored in RUN and while reset is asserted.
REQ-007 In IDLE or HALT, start=1 SHALL, on the next edge: move to RUN, set pc_out=0, load instr with word(0), set instr_valid=1, and clear the nop counter.
REQ-008 If load_en and start are asserted in the same cycle, both SHALL take effect, and the instr fetched on that edge SHALL use the memory contents from before the write.
REQ-009 In RUN with redirect_valid=1, the block SHALL on the next edge set pc_out={redirect_pc[7:2],2'b00}, load the word at that address, set instr_valid=1, and clear the nop counter, regardless of ready.
REQ-010 In RUN with redirect_valid=0 and instr_valid=1 and ready=1, the block SHALL on the next edge set pc_out=pc_out+4 mod 256 (252 wraps to 0) and load that word.
REQ-011 In RUN with instr_valid=1 and ready=0 and no redirect, instr and pc_out SHALL hold unchanged.
REQ-012 The 2-bit nop counter SHALL increment on each accept (instr_valid & ready) of instr==32'h0000_0000.
REQ-013 The nop counter SHALL clear on each accept of a nonzero instr.
REQ-014 When the third consecutive zero word is accepted, the block SHALL on the next edge enter HALT, set instr_valid=0 and halted=1, and clear the counter; this SHALL take priority over a simultaneous redirect.
REQ-015 In HALT, instr and pc_out SHALL hold their last values.
REQ-016 start and load SHALL be ignored in RUN.
REQ-017 In IDLE and HALT, redirect_valid and ready SHALL be ignored.
REQ-018 halted SHALL be 1 exactly when the state is HALT.
REQ-019 Fetch SHALL be a single-cycle registered read: the instr presented after an edge SHALL reflect memory as it was before that edge.

Reset
REQ-020 While reset=1 the block SHALL immediately set: state=IDLE, instr=32'h0, pc_out=8'h00, instr_valid=0, halted=0, nop counter=0.
REQ-021 Instruction memory contents SHALL NOT be altered by reset.
REQ-022 Reset asserted mid-RUN SHALL abort fetching with no further memory access.
REQ-023 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Load program, ready=1: load bytes 0..23 with the six-instruction program (word0=0x200a000a, word1=0x016a5820, word2=0x200a000d, word3=0x014b6022, word4=0xad4c0000, word5=0x8d4d0000), rest of memory zero, then pulse start -> instr sequence 0x200a000a, 0x016a5820, 0x200a000d, 0x014b6022, 0xad4c0000, 0x8d4d0000 at pc_out 0, 4, 8, 12, 16, 20 on consecutive cycles, followed by three zero words at pc_out 24, 28, 32; halted=1 on the next cycle with instr_valid=0.
- Backpressure: hold ready=0 for 3 cycles while pc_out=8 -> instr stays 0x200a000d and pc_out stays 8; pc_out advances to 12 one cycle after ready returns to 1.
- Redirect: redirect_valid=1 with redirect_pc=8'h11 while ready=0 at pc_out=4 -> next cycle pc_out=16, instr=0xad4c0000.
- Wrap-around: mem[252..255]=0x01,0x00,0x00,0x00; redirect to 252 -> instr=0x00000001; after accept, pc_out=0.
- Reset mid-run: assert reset at pc_out=12 -> instr_valid=0, pc_out=0, instr=0 without waiting for clk; after deassert and start, fetch resumes at pc_out=0 with word0 intact.
- Load ignored in RUN: load_en to address 0 with 0xFF during RUN -> after HALT and restart, word0 still 0x200a000a.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit with a 256-byte load-able instruction memory.
// Fetches little-endian 32-bit words starting at address 0, advances on
// accept, honours redirects, and halts after three consecutive zero words.
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [7:0]  load_data,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic        ready,
  output logic [31:0] instr,
  output logic [7:0]  pc_out,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t      state;
  logic [7:0]  mem [256];
  logic [1:0]  nop_cnt;

  logic        accept;
  logic        is_nop;
  logic [7:0]  seq_pc;
  logic [7:0]  redir_pc;

  // Little-endian word assembled from four bytes; address wraps mod 256.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  // Handshake and next-address terms shared by the FSM.
  always_comb begin
    accept   = instr_valid & ready;
    is_nop   = (instr == '0);
    seq_pc   = pc_out + 8'd4;
    redir_pc = redirect_pc & 8'hFC;
  end

  // Byte loads are accepted only outside RUN and never during reset.
  // The FSM reads the same array on this edge, so a concurrent start
  // sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (load_en && !reset && (state != RUN)) begin
      mem[load_addr] <= load_data;
    end
  end

  // Fetch FSM: registered instr/pc_out/instr_valid/halted and nop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      instr       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      nop_cnt     <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RUN;
            pc_out      <= '0;
            instr       <= word_at(8'h00);
            instr_valid <= 1'b1;
            halted      <= 1'b0;
            nop_cnt     <= '0;
          end
        end
        RUN: begin
          // Third consecutive accepted zero word wins over any redirect.
          if (accept && is_nop && (nop_cnt == 2'd2)) begin
            state       <= HALT;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            nop_cnt     <= '0;
          end else if (redirect_valid) begin
            pc_out      <= redir_pc;
            instr       <= word_at(redir_pc);
            instr_valid <= 1'b1;
            nop_cnt     <= '0;
          end else if (accept) begin
            pc_out  <= seq_pc;
            instr   <= word_at(seq_pc);
            nop_cnt <= is_nop ? nop_cnt + 2'd1 : 2'd0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic        start;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        ready;
  logic [31:0] instr;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic        halted;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [31:0] prog [6];
  logic [31:0] exp_seq [9];

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ready          (ready),
    .instr          (instr),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    prog = '{32'h200a000a, 32'h016a5820, 32'h200a000d,
             32'h014b6022, 32'hAD4C0000, 32'h8D4D0000};
    for (int i = 0; i < 9; i++) exp_seq[i] = (i < 6) ? prog[i] : 32'h0;

    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ready = 1'b0;

    // Reset values, asserted asynchronously
    #1 reset = 1'b1;
    #1;
    check("rst_instr", instr, 32'h0);
    check("rst_pc", {24'h0, pc_out}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Load program and clear the rest of memory
    for (int a = 0; a < 256; a++) begin
      logic [31:0] w;
      w = (a < 24) ? prog[a / 4] : 32'h0;
      load_byte(8'(a), w[8 * (a % 4) +: 8]);
    end
    check("idle_valid", {31'h0, instr_valid}, 32'h0);

    // Sequential fetch with ready=1 until halt; a load in RUN must be dropped
    ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("seq_pc%0d", i), {24'h0, pc_out}, 32'(4 * i));
      check($sformatf("seq_instr%0d", i), instr, exp_seq[i]);
      check($sformatf("seq_valid%0d", i), {31'h0, instr_valid}, 32'h1);
      if (i == 2) begin
        load_en = 1'b1; load_addr = 8'h00; load_data = 8'hFF;
      end
      tick();
      load_en = 1'b0;
    end
    check("halt_halted", {31'h0, halted}, 32'h1);
    check("halt_valid", {31'h0, instr_valid}, 32'h0);
    check("halt_pc_hold", {24'h0, pc_out}, 32'd32);
    check("halt_instr_hold", instr, 32'h0);

    // Restart: word0 untouched; then backpressure at pc 8
    pulse_start();
    check("restart_pc", {24'h0, pc_out}, 32'h0);
    check("restart_word0", instr, 32'h200a000a);
    check("restart_halted", {31'h0, halted}, 32'h0);
    tick();
    tick();
    check("bp_pc8", {24'h0, pc_out}, 32'd8);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_pc%0d", i), {24'h0, pc_out}, 32'd8);
      check($sformatf("bp_hold_instr%0d", i), instr, 32'h200a000d);
    end
    ready = 1'b1;
    tick();
    check("bp_resume_pc", {24'h0, pc_out}, 32'd12);
    check("bp_resume_instr", instr, 32'h014b6022);

    // Redirect back to 4, then redirect with ready=0 to 0x11 -> 0x10
    redirect_valid = 1'b1; redirect_pc = 8'h04;
    tick();
    check("redir4_pc", {24'h0, pc_out}, 32'd4);
    check("redir4_instr", instr, 32'h016a5820);
    ready = 1'b0; redirect_pc = 8'h11;
    tick();
    redirect_valid = 1'b0;
    check("redir_pc", {24'h0, pc_out}, 32'd16);
    check("redir_instr", instr, 32'hAD4C0000);

    // Run out to halt again: 20, 24, 28, 32, then HALT
    ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("halt2_halted", {31'h0, halted}, 32'h1);
    check("halt2_pc", {24'h0, pc_out}, 32'd32);

    // Redirect and ready ignored in HALT
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check("halt_redir_ign_pc", {24'h0, pc_out}, 32'd32);
    check("halt_redir_ign_halted", {31'h0, halted}, 32'h1);

    // Wrap-around fetch at 252
    load_byte(8'd252, 8'h01);
    ready = 1'b0;
    pulse_start();
    redirect_valid = 1'b1; redirect_pc = 8'd252;
    tick();
    redirect_valid = 1'b0;
    check("wrap_pc", {24'h0, pc_out}, 32'd252);
    check("wrap_instr", instr, 32'h00000001);
    ready = 1'b1;
    tick();
    check("wrap_next_pc", {24'h0, pc_out}, 32'd0);
    check("wrap_next_instr", instr, 32'h200a000a);

    // Reset mid-run at pc 12, checked before any clock edge
    tick(); tick(); tick();
    check("midrun_pc12", {24'h0, pc_out}, 32'd12);
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'h0, instr_valid}, 32'h0);
    check("async_rst_pc", {24'h0, pc_out}, 32'h0);
    check("async_rst_instr", instr, 32'h0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("post_rst_idle", {31'h0, instr_valid}, 32'h0);
    pulse_start();
    check("post_rst_pc", {24'h0, pc_out}, 32'h0);
    check("post_rst_word0", instr, 32'h200a000a);
    check("post_rst_valid", {31'h0, instr_valid}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
